// File: rtl/if_id_buffer_pkg.sv
// Shared defines for the fetch/decode boundary: NOP encoding,
// opcode field bounds and the SYSTEM opcode value.
package if_id_buffer_pkg;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam int          OPC_HI       = 6;
  localparam int          OPC_LO       = 2;
  localparam logic [4:0]  OPCODE_SYSTEM = 5'b11100;

endpackage

// File: rtl/if_id_buffer_fifo2.sv
// fifo2: two-entry FIFO with 1-bit pointers and a 0..2 count.
// Flush empties it without touching the stored words.
module fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wp;
  logic         rp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rp];

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID skid buffer with sticky halt; optional illegal-length
// flag enabled by IF_ID_ILLEGAL_CHECK_EN.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [4:0]      out_opcode,
  input  logic            flush,
  input  logic            halt,
  output logic            halted,
  output logic            out_illegal
);

  logic [1:0]        count;
  logic [2*XLEN-1:0] head;
  logic              push;
  logic              pop;

  assign in_ready  = (count != 2'd2) && !halted;
  assign out_valid = (count != 2'd0) && !halted;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  fifo2 #(.W(2*XLEN)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({in_pc, in_inst}),
    .rdata (head),
    .count (count)
  );

  // halted survives flush; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted <= 1'b0;
    else if (halt && out_valid && out_ready) halted <= 1'b1;
  end

  assign out_pc     = out_valid ? head[2*XLEN-1:XLEN] : '0;
  assign out_inst   = out_valid ? head[XLEN-1:0] : NOP_INST;
  assign out_opcode = out_inst[OPC_HI:OPC_LO];

`ifdef IF_ID_ILLEGAL_CHECK_EN
  assign out_illegal = out_valid && (out_inst[1:0] != 2'b11);
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: queue model plus directed scenarios,
// followed by randomized traffic.
module tb_if_id_buffer;

`ifdef IF_ID_ILLEGAL_CHECK_EN
  localparam bit ILL = 1'b1;
`else
  localparam bit ILL = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [4:0]  out_opcode;
  logic        halted;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_inst     (in_inst),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_opcode  (out_opcode),
    .flush       (flush),
    .halt        (halt),
    .halted      (halted),
    .out_illegal (out_illegal)
  );

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endfunction

  // reference model: queue of {pc,inst} plus sticky halt bit
  logic [63:0] q[$];
  bit          hm;

  always @(posedge clk or posedge rst) begin
    bit ir;
    bit ov;
    if (rst) begin
      q.delete();
      hm = 1'b0;
    end else begin
      ir = (q.size() < 2) && !hm;
      ov = (q.size() > 0) && !hm;
      if (flush) q.delete();
      else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back({in_pc, in_inst});
      end
      if (halt && ov && out_ready) hm = 1'b1;
    end
  end

  always @(negedge clk) begin
    bit          ov;
    logic [63:0] h;
    if (!rst) begin
      ov = (q.size() > 0) && !hm;
      h  = ov ? q[0] : {32'h0, NOP};
      chk("m_in_ready", 32'(in_ready), 32'((q.size() < 2) && !hm));
      chk("m_out_valid", 32'(out_valid), 32'(ov));
      chk("m_out_pc", out_pc, h[63:32]);
      chk("m_out_inst", out_inst, h[31:0]);
      chk("m_out_opcode", 32'(out_opcode), 32'((h[31:0] >> 2) & 32'h1f));
      chk("m_halted", 32'(halted), 32'(hm));
      chk("m_out_illegal", 32'(out_illegal),
          32'(ILL && ov && (h[1:0] != 2'b11)));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, NOP);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);

    // single push then pop
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h0050_0093;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("p1_out_valid", 32'(out_valid), 32'd1);
    chk("p1_opcode", 32'(out_opcode), 32'b00100);
    chk("p1_out_pc", out_pc, 32'h0);
    @(negedge clk);
    chk("p1_empty", 32'(out_valid), 32'd0);

    // back-pressure: third push refused
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0; in_inst = 32'h0010_0093;
    @(negedge clk);
    in_pc = 32'h4;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    in_pc = 32'h8;
    @(negedge clk);
    chk("bp_third_refused", 32'(in_ready), 32'd0);
    chk("bp_head0", out_pc, 32'h0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_head1", out_pc, 32'h4);
    @(negedge clk);
    chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // flush beats a simultaneous push at count 2
    in_valid = 1'b1; in_pc = 32'h10;
    @(negedge clk);
    in_pc = 32'h14;
    @(negedge clk);
    flush = 1'b1; in_pc = 32'h18;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_inst", out_inst, 32'h0000_0013);
    chk("fl_in_ready", 32'(in_ready), 32'd1);

    // halt on ECALL; flush keeps halted
    in_valid = 1'b1; in_pc = 32'h20; in_inst = 32'h0000_0073;
    @(negedge clk);
    in_valid = 1'b0; halt = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_in_ready", 32'(in_ready), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    chk("h_after_flush", 32'(halted), 32'd1);

    // compressed-looking word
    do_reset();
    in_valid = 1'b1; in_pc = 32'h30; in_inst = 32'h0000_4501;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_flag", 32'(out_illegal), 32'(ILL));

    // asynchronous reset mid-push
    do_reset();
    in_valid = 1'b1; in_pc = 32'h40; in_inst = 32'h0010_0093;
    @(negedge clk);
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    in_pc = 32'h44;
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_out_inst", out_inst, NOP);
    chk("ar_out_pc", out_pc, 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ar_no_push", 32'(out_valid), 32'd0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) do_reset();
      @(negedge clk);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 16) == 0;
      halt      = ($urandom % 64) == 0;
      in_pc     = $urandom;
      in_inst   = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; halt = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the width of the PC and instruction datapath.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), which out_inst drives while the buffer is empty.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset; this is already decided.
REQ-005 SHALL have port in_valid  in  1  fetch presents an instruction.
REQ-006 SHALL have port in_ready  out  1  buffer accepts the instruction this cycle.
REQ-007 SHALL have port in_pc  in  XLEN  PC of the fetched instruction.
REQ-008 SHALL have port in_inst  in  XLEN  fetched instruction word.
REQ-009 SHALL have port out_valid  out  1  head entry is valid for decode.
REQ-010 SHALL have port out_ready  in  1  decode consumes the head this cycle.
REQ-011 SHALL have port out_pc  out  XLEN  PC of the head entry.
REQ-012 SHALL have port out_inst  out  XLEN  head instruction word.
REQ-013 SHALL have port out_opcode  out  5  out_inst[6:2], fed to the control unit's opcode input.
REQ-014 SHALL have port flush  in  1  taken branch/jump redirect; discards all entries.
REQ-015 SHALL have port halt  in  1  control unit b_flag (ECALL/EBREAK) for the head instruction.
REQ-016 SHALL have port halted  out  1  sticky halt status.
REQ-017 SHALL have port out_illegal  out  1  head word is not a 32-bit encoding (see Configuration).

Function
REQ-018 SHALL hold 2 entries {pc, inst} in FIFO order, using a 2-bit count (0..2) and 1-bit read/write pointers.
REQ-019 SHALL drive in_ready = (count != 2) && !halted.
REQ-020 SHALL push when in_valid && in_ready && !flush, and pop when out_valid && out_ready && !flush.
REQ-021 SHALL have a latency of 1 cycle: a word pushed at edge N is visible at the outputs, with out_valid high, after edge N.
REQ-022 SHALL, on a simultaneous push and pop at count 1, leave count at 1 and present the new entry as head after the edge.
REQ-023 SHALL drive out_valid = (count != 0) && !halted.
REQ-024 SHALL drive out_pc and out_inst from the head entry when out_valid is high; otherwise out_pc = 0 and out_inst = NOP_INST.
REQ-025 SHALL, when flush is high, set count to 0 and both pointers to 0 at the next edge; flush overrides any push or pop in the same cycle.
REQ-026 SHALL set halted at the next edge when halt && out_valid && out_ready; halted stays set until rst, and flush does not clear it.
REQ-027 SHALL neither push nor pop while halted, and SHALL leave entry contents unchanged.
REQ-028 SHALL hold all entries when out_ready is low and count is 2 (back-pressure); in this case in_ready is low.

Reset
REQ-029 SHALL, on rst assertion and asynchronously, clear count, pointers, halted and all entry storage to 0, giving outputs out_valid=0, out_pc=0, out_inst=NOP_INST, out_illegal=0, halted=0 and in_ready=1 once rst deasserts.
REQ-030 SHALL discard any in-flight push or pop when rst asserts mid-cycle.

Configuration
REQ-031 SHALL, with macro IF_ID_ILLEGAL_CHECK_EN defined, drive out_illegal = out_valid && (out_inst[1:0] != 2'b11).
REQ-032 SHALL, without IF_ID_ILLEGAL_CHECK_EN, tie out_illegal to 0; all other behaviour is identical.

Structure
REQ-033 SHALL take the NOP encoding, the opcode field bounds [6:2], and the OPCODE_SYSTEM value from the shared defines package; none SHALL be duplicated locally.
REQ-034 SHALL instantiate the storage, pointers and count as one sub-module, fifo2, parameterised by width; flag and halt logic SHALL stay in if_id_buffer.

Verification
REQ-035 SHALL be verified by: push pc=0x0 inst=0x00500093 with out_ready=1 -> out_valid=1, out_opcode=5'b00100, out_pc=0x0 on the next cycle, empty after the pop.
REQ-036 SHALL be verified by: out_ready=0, three pushes (pc 0x0/0x4/0x8) -> in_ready=0 after the second push, the third is not accepted, and pops return 0x0 then 0x4.
REQ-037 SHALL be verified by: count=2 with flush=1 and in_valid=1 in the same cycle -> count=0, out_valid=0 and out_inst=0x00000013 next cycle.
REQ-038 SHALL be verified by: head inst=0x00000073 with halt=1 and out_ready=1 -> halted=1 and in_ready=0, and a later flush leaves halted=1.
REQ-039 SHALL be verified by: with IF_ID_ILLEGAL_CHECK_EN, push inst=0x00004501 -> out_illegal=1; without the macro -> out_illegal=0.
REQ-040 SHALL be verified by: rst asserted mid-push at count=1 -> outputs take their reset values immediately, without waiting for clk.
